// File: rtl/uart_loader_ctrl_pkg.sv
// Shared types and constants for the UART boot loader packet controller.
package uart_loader_ctrl_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR_H,
    ST_ADDR_L,
    ST_CNT_H,
    ST_CNT_L,
    ST_DATA_H,
    ST_DATA_L,
    ST_WRITE,
    ST_CKSUM,
    ST_FINISH
  } state_t;

  localparam logic [1:0] ERR_NONE = 2'd0;
  localparam logic [1:0] ERR_GAP  = 2'd1;
  localparam logic [1:0] ERR_OVR  = 2'd2;
  localparam logic [1:0] ERR_HDR  = 2'd3;

  localparam logic [7:0] DEFAULT_SYNC = 8'hA5;

  // States that take a packet byte from the skid buffer or the receiver.
  function automatic logic is_parse_state(input state_t s);
    return (s inside {ST_ADDR_H, ST_ADDR_L, ST_CNT_H, ST_CNT_L,
                      ST_DATA_H, ST_DATA_L, ST_CKSUM});
  endfunction

endpackage

// File: rtl/uart_loader_ctrl_skid.sv
// One-entry byte buffer holding a received byte while a memory write is pending.
module uart_loader_skid (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr,
  input  logic       push,
  input  logic       pop,
  input  logic [7:0] din,
  output logic       full,
  output logic [7:0] dout,
  output logic       overrun
);

  logic       full_q, full_d;
  logic [7:0] data_q, data_d;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    if (clr) begin
      full_d = 1'b0;
    end else if (push) begin
      full_d = 1'b1;
      data_d = din;
    end else if (pop) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign full    = full_q;
  assign dout    = data_q;
  assign overrun = push && full_q && !pop && !clr;

endmodule

// File: rtl/uart_loader_ctrl.sv
// UART load-packet parser and LC-3 memory write sequencer.
// Define UART_LOADER_CHECKSUM_EN to require a trailing XOR checksum byte.
module uart_loader_ctrl
  import uart_loader_ctrl_pkg::*;
#(
  parameter logic [7:0]  SYNC_BYTE = DEFAULT_SYNC,
  parameter logic [15:0] MAX_WORDS = 16'hFFFF
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        rx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_idle,
  input  logic        rx_eop,
  output logic        mem_req,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_wdata,
  input  logic        mem_ack,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [1:0]  err_code,
  output logic [15:0] entry_addr
);

`ifdef UART_LOADER_CHECKSUM_EN
  localparam state_t END_ST = ST_CKSUM;
`else
  localparam state_t END_ST = ST_FINISH;
`endif

  state_t      state_q, state_d;
  logic [15:0] start_q, start_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] cnt_q, cnt_d;
  logic [15:0] data_q, data_d;
  logic [15:0] entry_q, entry_d;
  logic [1:0]  err_code_q, err_code_d;
  logic        err_q, err_d;
  logic        err_pend_q, err_pend_d;
`ifdef UART_LOADER_CHECKSUM_EN
  logic [7:0]  cksum_q, cksum_d;
`endif

  logic        parse, byte_vld, fail;
  logic [7:0]  byte_val;
  logic [1:0]  fail_code;
  logic [15:0] cnt_new;
  logic        skid_full, skid_push, skid_pop, skid_overrun;
  logic [7:0]  skid_dout;
  logic        unused_rx_idle;

  assign unused_rx_idle = rx_idle;

  // Buffered byte always goes first; a coincident new byte refills the slot.
  assign parse     = is_parse_state(state_q);
  assign skid_pop  = parse && skid_full;
  assign skid_push = rx_ready && ((state_q == ST_WRITE) || skid_pop);
  assign byte_vld  = parse && (skid_full || rx_ready);
  assign byte_val  = skid_full ? skid_dout : rx_data;

  uart_loader_skid u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (state_q == ST_IDLE),
    .push    (skid_push),
    .pop     (skid_pop),
    .din     (rx_data),
    .full    (skid_full),
    .dout    (skid_dout),
    .overrun (skid_overrun)
  );

  always_comb begin
    state_d    = state_q;
    start_d    = start_q;
    addr_d     = addr_q;
    cnt_d      = cnt_q;
    data_d     = data_q;
    entry_d    = entry_q;
    err_code_d = err_code_q;
    err_pend_d = err_pend_q;
    err_d      = 1'b0;
    fail       = 1'b0;
    fail_code  = ERR_NONE;
    cnt_new    = {cnt_q[15:8], byte_val};
`ifdef UART_LOADER_CHECKSUM_EN
    cksum_d    = cksum_q;
`endif

    if (state_q == ST_IDLE) begin
      if (rx_ready && (rx_data == SYNC_BYTE)) begin
        state_d    = ST_ADDR_H;
        err_code_d = ERR_NONE;
        err_pend_d = 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
        cksum_d    = '0;
`endif
      end
    end else if (parse) begin
      if (rx_eop) begin
        fail      = 1'b1;
        fail_code = ERR_GAP;
      end else if (byte_vld) begin
`ifdef UART_LOADER_CHECKSUM_EN
        cksum_d = cksum_q ^ byte_val;
`endif
        case (state_q)
          ST_ADDR_H: begin
            start_d[15:8] = byte_val;
            state_d       = ST_ADDR_L;
          end
          ST_ADDR_L: begin
            start_d[7:0] = byte_val;
            addr_d       = {start_q[15:8], byte_val};
            state_d      = ST_CNT_H;
          end
          ST_CNT_H: begin
            cnt_d[15:8] = byte_val;
            state_d     = ST_CNT_L;
          end
          ST_CNT_L: begin
            cnt_d = cnt_new;
            if (cnt_new > MAX_WORDS) begin
              fail      = 1'b1;
              fail_code = ERR_HDR;
            end else if (cnt_new == '0) begin
              state_d = END_ST;
            end else begin
              state_d = ST_DATA_H;
            end
          end
          ST_DATA_H: begin
            data_d[15:8] = byte_val;
            state_d      = ST_DATA_L;
          end
          ST_DATA_L: begin
            data_d[7:0] = byte_val;
            state_d     = ST_WRITE;
          end
`ifdef UART_LOADER_CHECKSUM_EN
          ST_CKSUM: begin
            if (byte_val == cksum_q) begin
              state_d = ST_FINISH;
            end else begin
              fail      = 1'b1;
              fail_code = ERR_HDR;
            end
          end
`endif
          default: state_d = ST_IDLE;
        endcase
      end
    end else if (state_q == ST_WRITE) begin
      // An overrun is only reported once the outstanding write is acked.
      if (skid_overrun) begin
        err_pend_d = 1'b1;
      end
      if (mem_ack) begin
        addr_d = addr_q + 16'd1;
        cnt_d  = cnt_q - 16'd1;
        if (err_pend_q || skid_overrun) begin
          fail      = 1'b1;
          fail_code = ERR_OVR;
        end else if (cnt_q == 16'd1) begin
          state_d = END_ST;
        end else begin
          state_d = ST_DATA_H;
        end
      end
    end else begin
      state_d = ST_IDLE;
    end

    if (fail) begin
      state_d    = ST_IDLE;
      err_d      = 1'b1;
      err_code_d = fail_code;
    end

    if ((state_d == ST_FINISH) && (state_q != ST_FINISH)) begin
      entry_d = start_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      start_q    <= '0;
      addr_q     <= '0;
      cnt_q      <= '0;
      data_q     <= '0;
      entry_q    <= '0;
      err_code_q <= ERR_NONE;
      err_q      <= 1'b0;
      err_pend_q <= 1'b0;
`ifdef UART_LOADER_CHECKSUM_EN
      cksum_q    <= '0;
`endif
    end else begin
      state_q    <= state_d;
      start_q    <= start_d;
      addr_q     <= addr_d;
      cnt_q      <= cnt_d;
      data_q     <= data_d;
      entry_q    <= entry_d;
      err_code_q <= err_code_d;
      err_q      <= err_d;
      err_pend_q <= err_pend_d;
`ifdef UART_LOADER_CHECKSUM_EN
      cksum_q    <= cksum_d;
`endif
    end
  end

  assign mem_req    = (state_q == ST_WRITE);
  assign mem_addr   = addr_q;
  assign mem_wdata  = data_q;
  assign busy       = (state_q != ST_IDLE) && (state_q != ST_FINISH);
  assign done       = (state_q == ST_FINISH);
  assign err        = err_q;
  assign err_code   = err_code_q;
  assign entry_addr = entry_q;

endmodule

// File: tb/tb_uart_loader_ctrl.sv
// Self-checking bench for uart_loader_ctrl; honours UART_LOADER_CHECKSUM_EN.
module tb_uart_loader_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rx_ready;
  logic [7:0]  rx_data;
  logic        rx_idle;
  logic        rx_eop;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic        busy;
  logic        done;
  logic        err;
  logic [1:0]  err_code;
  logic [15:0] entry_addr;

  uart_loader_ctrl #(.SYNC_BYTE(8'hA5), .MAX_WORDS(16'hFFFF)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_ready   (rx_ready),
    .rx_data    (rx_data),
    .rx_idle    (rx_idle),
    .rx_eop     (rx_eop),
    .mem_req    (mem_req),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_ack    (mem_ack),
    .busy       (busy),
    .done       (done),
    .err        (err),
    .err_code   (err_code),
    .entry_addr (entry_addr)
  );

  always #5 clk = ~clk;

  int unsigned n_assert = 0;
  int unsigned n_fail   = 0;
  int unsigned cyc      = 0;
  int unsigned done_cnt = 0;
  int unsigned err_cnt  = 0;
  int unsigned done_cyc = 0;
  int unsigned ack_cyc  = 0;
  int unsigned wait_cnt = 0;
  int unsigned ack_delay;
  logic        ack_hold;
  int unsigned d0, e0, w0;

  logic [15:0] wq_addr[$];
  logic [15:0] wq_data[$];
  logic [15:0] words[$];
  logic [7:0]  pkt[$];
  logic [15:0] last_entry;

  always @(posedge clk) cyc++;

  always @(negedge clk) begin
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
    if (err) err_cnt++;
  end

  // Memory model: acks ack_delay cycles after a request, logs each accepted write.
  always @(negedge clk) begin
    mem_ack = 1'b0;
    if (!mem_req) begin
      wait_cnt = 0;
    end else if (!ack_hold) begin
      if (wait_cnt >= ack_delay) begin
        mem_ack = 1'b1;
        wq_addr.push_back(mem_addr);
        wq_data.push_back(mem_wdata);
        ack_cyc  = cyc;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send_byte(input logic [7:0] b, input int unsigned gap);
    @(negedge clk);
    rx_ready = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_ready = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic send_range(input int unsigned first, input int unsigned last, input int unsigned gap);
    for (int unsigned i = first; i < last; i++) send_byte(pkt[i], gap);
  endtask

  task automatic rand_words(input int unsigned n);
    words.delete();
    for (int unsigned i = 0; i < n; i++) words.push_back(16'($urandom));
  endtask

  // Packet image from the framing rules: sync, address, count, words, optional XOR.
  task automatic build_pkt(input logic [15:0] start);
    logic [15:0] n16;
    logic [7:0]  x;
    n16 = 16'(words.size());
    pkt.delete();
    pkt.push_back(8'hA5);
    pkt.push_back(start[15:8]);
    pkt.push_back(start[7:0]);
    pkt.push_back(n16[15:8]);
    pkt.push_back(n16[7:0]);
    foreach (words[i]) begin
      pkt.push_back(words[i][15:8]);
      pkt.push_back(words[i][7:0]);
    end
    x = 8'h00;
    for (int unsigned i = 1; i < pkt.size(); i++) x = x ^ pkt[i];
`ifdef UART_LOADER_CHECKSUM_EN
    pkt.push_back(x);
`endif
  endtask

  task automatic begin_pkt();
    d0 = done_cnt;
    e0 = err_cnt;
    w0 = wq_addr.size();
  endtask

  task automatic finish_check(input string tag, input logic [15:0] start, input logic exp_done,
                              input logic [1:0] exp_code, input int unsigned nw);
    int unsigned k;
    logic [15:0] ea;
    k = 0;
    while ((done_cnt == d0) && (err_cnt == e0) && (k < 3000)) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_timeout"}, 32'(k < 3000), 32'd1);
    repeat (3) @(negedge clk);
    chk({tag, "_done"}, done_cnt - d0, 32'(exp_done));
    chk({tag, "_err"}, err_cnt - e0, 32'(!exp_done));
    chk({tag, "_code"}, 32'(err_code), 32'(exp_code));
    if (exp_done) last_entry = start;
    chk({tag, "_entry"}, 32'(entry_addr), 32'(last_entry));
    chk({tag, "_nwrites"}, wq_addr.size() - w0, nw);
    for (int unsigned i = 0; i < nw; i++) begin
      if (w0 + i < wq_addr.size()) begin
        ea = start + i[15:0];
        chk({tag, "_waddr"}, 32'(wq_addr[w0 + i]), 32'(ea));
        chk({tag, "_wdata"}, 32'(wq_data[w0 + i]), 32'(words[i]));
      end
    end
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_req"}, 32'(mem_req), 32'd0);
  endtask

  initial begin
    logic [15:0] st;
    rst_n     = 1'b0;
    rx_ready  = 1'b0;
    rx_data   = 8'h00;
    rx_idle   = 1'b1;
    rx_eop    = 1'b0;
    ack_hold  = 1'b0;
    ack_delay = 0;
    last_entry = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(mem_req), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_code", 32'(err_code), 32'd0);
    chk("rst_entry", 32'(entry_addr), 32'd0);
    rst_n = 1'b1;
    rx_idle = 1'b0;
    repeat (2) @(negedge clk);

    // Noise before sync is discarded.
    send_byte(8'h00, 2);
    send_byte(8'h11, 2);
    chk("noise_busy", 32'(busy), 32'd0);

    // Reference packet, immediate ack.
    words.delete();
    words.push_back(16'h1234);
    words.push_back(16'hABCD);
    build_pkt(16'h3000);
    begin_pkt();
    send_byte(pkt[0], 2);
    chk("sync_busy", 32'(busy), 32'd1);
    send_range(1, pkt.size(), 3);
    finish_check("basic", 16'h3000, 1'b1, 2'd0, 2);
`ifndef UART_LOADER_CHECKSUM_EN
    chk("done_latency", done_cyc - ack_cyc, 32'd1);
`endif

    // Slow memory: one byte waits in the skid buffer.
    ack_delay = 200;
    begin_pkt();
    send_range(0, pkt.size(), 150);
    finish_check("skid", 16'h3000, 1'b1, 2'd0, 2);

    // Ack stalled across two byte arrivals.
    ack_delay = 0;
    ack_hold  = 1'b1;
    begin_pkt();
    send_range(0, 7, 3);
    send_range(7, 9, 3);
    chk("ovr_noerr_yet", err_cnt - e0, 32'd0);
    chk("ovr_req_held", 32'(mem_req), 32'd1);
    ack_hold = 1'b0;
    finish_check("ovr", 16'h3000, 1'b0, 2'd2, 1);

    // Address wrap.
    rand_words(2);
    build_pkt(16'hFFFF);
    begin_pkt();
    send_range(0, pkt.size(), 2);
    finish_check("wrap", 16'hFFFF, 1'b1, 2'd0, 2);

    // Gap after header.
    rand_words(2);
    build_pkt(16'h3000);
    begin_pkt();
    send_range(0, 5, 2);
    @(negedge clk);
    rx_eop = 1'b1;
    @(negedge clk);
    rx_eop = 1'b0;
    finish_check("gap", 16'h3000, 1'b0, 2'd1, 0);

    // Reset in the middle of the data phase.
    rand_words(2);
    build_pkt(16'h4000);
    begin_pkt();
    send_range(0, 8, 3);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    last_entry = 16'h0000;
    chk("mrst_req", 32'(mem_req), 32'd0);
    chk("mrst_addr", 32'(mem_addr), 32'd0);
    chk("mrst_wdata", 32'(mem_wdata), 32'd0);
    chk("mrst_busy", 32'(busy), 32'd0);
    chk("mrst_code", 32'(err_code), 32'd0);
    chk("mrst_entry", 32'(entry_addr), 32'(last_entry));
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("mrst_noerr", err_cnt - e0, 32'd0);
    chk("mrst_nodone", done_cnt - d0, 32'd0);

`ifdef UART_LOADER_CHECKSUM_EN
    rand_words(2);
    build_pkt(16'h5000);
    pkt[pkt.size() - 1] = pkt[pkt.size() - 1] ^ 8'hFF;
    begin_pkt();
    send_range(0, pkt.size(), 2);
    finish_check("cksum", 16'h5000, 1'b0, 2'd3, 2);
`endif

    // Random packets with mild memory back-pressure.
    for (int unsigned t = 0; t < 8; t++) begin
      st = 16'($urandom);
      rand_words($urandom_range(1, 5));
      build_pkt(st);
      ack_delay = $urandom_range(0, 10);
      begin_pkt();
      send_range(0, pkt.size(), $urandom_range(6, 10));
      finish_check("rand", st, 1'b1, 2'd0, words.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
